change_return_dispenser: RTL and testbench

- Sits downstream of the vending machine current-state/totals logic.
- Consumes the running balance and the return trigger, and runs the wait-time countdown.
- On a return request or timeout, dispenses change greedily, one coin per cycle, largest denomination first.
- Each dispensed coin drives o_return_coin, which the upstream logic uses to accumulate its return total.

---
 rtl/change_return_dispenser.sv | 165 ++++++++++++++++
 tb/tb_change_return_dispenser.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/change_return_dispenser.sv
// Change return dispenser: idle timer, return request handling and greedy one-coin-per-cycle payout.
// Optional feature macro: RETURN_COUNT_EN adds o_return_count (coins dispensed in current/last return).
module change_return_dispenser #(
  parameter int NUM_COINS  = 3,
  parameter int NUM_ITEMS  = 4,
  parameter int TOTAL_BITS = 31,
  parameter int WAIT_TIME  = 100,
  parameter int COIN_VAL0  = 100,
  parameter int COIN_VAL1  = 500,
  parameter int COIN_VAL2  = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_COINS-1:0]  i_input_coin,
  input  logic [NUM_ITEMS-1:0]  i_select_item,
  input  logic                  i_trigger_return,
  input  logic [TOTAL_BITS-1:0] i_balance_total,
  output logic [NUM_COINS-1:0]  o_return_coin,
  output logic                  o_return_flag,
  output logic [31:0]           o_wait_time,
`ifdef RETURN_COUNT_EN
  output logic [7:0]            o_return_count,
`endif
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RETURN = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic [TOTAL_BITS-1:0] remain_r, remain_s;
  logic                  pending_r, pending_s;
  logic [31:0]           wait_r, wait_s;
  logic [NUM_COINS-1:0]  coin_r, coin_s;
  logic                  flag_r, flag_s;
  logic                  busy_r, busy_s;
  logic                  reload_s, timeout_s, request_s, fit_s;
  int                    sel_s;

  // Coin value table, zero-extended to the balance width.
  function automatic logic [TOTAL_BITS-1:0] coin_val(input int idx);
    logic [TOTAL_BITS-1:0] val;
    if (idx == 0)      val = TOTAL_BITS'(COIN_VAL0);
    else if (idx == 1) val = TOTAL_BITS'(COIN_VAL1);
    else if (idx == 2) val = TOTAL_BITS'(COIN_VAL2);
    else               val = {TOTAL_BITS{1'b0}};
    return val;
  endfunction

  // Largest denomination that still fits in the remaining amount.
  always_comb begin
    sel_s = 0;
    fit_s = 1'b0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (coin_val(k) <= remain_r) begin
        sel_s = k;
        fit_s = 1'b1;
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Next-state, timer and registered-output decode.
  always_comb begin
    state_s   = state_r;
    remain_s  = remain_r;
    pending_s = pending_r;
    wait_s    = 32'(WAIT_TIME);
    coin_s    = {NUM_COINS{1'b0}};
    flag_s    = 1'b0;
    reload_s  = (|i_input_coin) | (|i_select_item);
    timeout_s = (wait_r == 32'd0) && !reload_s;
    request_s = i_trigger_return | pending_r;
    case (state_r)
      IDLE: begin
        if (reload_s)               wait_s = 32'(WAIT_TIME);
        else if (wait_r != 32'd0)   wait_s = wait_r - 32'd1;
        else                        wait_s = wait_r;
        // A coin landing with the request defers it until the balance absorbs the coin.
        if (request_s && (|i_input_coin)) begin
          pending_s = 1'b1;
        end else if (request_s || timeout_s) begin
          pending_s = 1'b0;
          if (i_balance_total != {TOTAL_BITS{1'b0}}) begin
            state_s  = RETURN;
            remain_s = i_balance_total;
            wait_s   = 32'(WAIT_TIME);
          end else begin
            state_s = IDLE;
          end
        end else begin
          pending_s = pending_r;
        end
      end
      RETURN: begin
        if (fit_s) begin
          coin_s   = NUM_COINS'(1'b1) << sel_s;
          remain_s = remain_r - coin_val(sel_s);
        end else begin
          state_s = DONE;
          flag_s  = 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s   = IDLE;
        remain_s  = {TOTAL_BITS{1'b0}};
        pending_s = 1'b0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      remain_r  <= {TOTAL_BITS{1'b0}};
      pending_r <= 1'b0;
      wait_r    <= 32'(WAIT_TIME);
      coin_r    <= {NUM_COINS{1'b0}};
      flag_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      remain_r  <= remain_s;
      pending_r <= pending_s;
      wait_r    <= wait_s;
      coin_r    <= coin_s;
      flag_r    <= flag_s;
      busy_r    <= busy_s;
    end
  end

`ifdef RETURN_COUNT_EN
  logic [7:0] count_r;

  // Coins dispensed in the current or most recent return sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 8'd0;
    end else if (state_r == IDLE && state_s == RETURN) begin
      count_r <= 8'd0;
    end else if (coin_s != {NUM_COINS{1'b0}}) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign o_return_count = count_r;
`endif

  assign o_return_coin = coin_r;
  assign o_return_flag = flag_r;
  assign o_wait_time   = wait_r;
  assign o_busy        = busy_r;

endmodule

// File: tb/tb_change_return_dispenser.sv
// Scoreboard bench for change_return_dispenser: expected coin/flag events are queued with
// their cycle stamp; a monitor compares every nonzero output against the queue head.
module tb_change_return_dispenser;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  i_input_coin;
  logic [3:0]  i_select_item;
  logic        i_trigger_return;
  logic [30:0] i_balance_total;
  logic [2:0]  o_return_coin;
  logic        o_return_flag;
  logic [31:0] o_wait_time;
  logic        o_busy;
`ifdef RETURN_COUNT_EN
  logic [7:0]  o_return_count;
`endif

  typedef struct {
    int         cyc;
    logic [2:0] coin;
    logic       flag;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;

  change_return_dispenser #(
    .NUM_COINS(3), .NUM_ITEMS(4), .TOTAL_BITS(31), .WAIT_TIME(5),
    .COIN_VAL0(100), .COIN_VAL1(500), .COIN_VAL2(1000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_input_coin(i_input_coin),
    .i_select_item(i_select_item),
    .i_trigger_return(i_trigger_return),
    .i_balance_total(i_balance_total),
    .o_return_coin(o_return_coin),
    .o_return_flag(o_return_flag),
    .o_wait_time(o_wait_time),
`ifdef RETURN_COUNT_EN
    .o_return_count(o_return_count),
`endif
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every dispensed coin or flag must match the queue head, including its cycle.
  always @(negedge clk) begin
    if (o_return_coin != 3'b000 || o_return_flag) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: cyc=%0d coin=%b flag=%b, required no event", cyc, o_return_coin, o_return_flag);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.coin != o_return_coin || e.flag != o_return_flag) begin
          fails++;
          $display("FAIL event: got cyc=%0d coin=%b flag=%b, required cyc=%0d coin=%b flag=%b",
                   cyc, o_return_coin, o_return_flag, e.cyc, e.coin, e.flag);
        end
      end
    end
  end

  task automatic push(input int c, input logic [2:0] coin, input logic flag);
    ev_t e;
    e.cyc = c; e.coin = coin; e.flag = flag;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d required %0d (cyc=%0d)", name, actual, expected, cyc);
    end
  endtask

  // Advance to just after posedge number c (input drive point).
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    goto(c);
    @(negedge clk);
  endtask

  task automatic do_reset(output int r);
    reset = 1'b1;
    i_input_coin = 3'b000;
    i_select_item = 4'b0000;
    i_trigger_return = 1'b0;
    i_balance_total = 31'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    r = cyc;
  endtask

  initial begin
    int r;
    // Case 1: 1700 -> 1000, 500, 100, 100, then flag.
    do_reset(r);
    chk("reset_wait", o_wait_time, 5);
    chk("reset_busy", o_busy, 0);
    i_balance_total = 31'd1700;
    i_trigger_return = 1'b1;
    push(r + 2, 3'b100, 1'b0);
    push(r + 3, 3'b010, 1'b0);
    push(r + 4, 3'b001, 1'b0);
    push(r + 5, 3'b001, 1'b0);
    push(r + 6, 3'b000, 1'b1);
    goto(r + 1);
    i_trigger_return = 1'b0;
    at_neg(r + 3);
    chk("c1_busy_mid", o_busy, 1);
    chk("c1_wait_hold", o_wait_time, 5);
    at_neg(r + 7);
    chk("c1_busy_after", o_busy, 0);
    chk("c1_wait_after", o_wait_time, 5);
`ifdef RETURN_COUNT_EN
    chk("c1_count", o_return_count, 4);
`endif
    chk("c1_queue_empty", q.size(), 0);

    // Case 2: timeout with balance 600 -> 500, 100, flag.
    do_reset(r);
    i_balance_total = 31'd600;
    push(r + 7, 3'b010, 1'b0);
    push(r + 8, 3'b001, 1'b0);
    push(r + 9, 3'b000, 1'b1);
    for (int k = 0; k <= 5; k++) begin
      at_neg(r + k);
      chk("c2_wait_count", o_wait_time, 5 - k);
    end
    at_neg(r + 7);
    chk("c2_busy_mid", o_busy, 1);
    at_neg(r + 10);
    chk("c2_wait_reload", o_wait_time, 5);
    chk("c2_busy_after", o_busy, 0);
    chk("c2_queue_empty", q.size(), 0);

    // Case 3: coin at wait 2 reloads the timer; return only after the full count.
    do_reset(r);
    i_balance_total = 31'd100;
    push(r + 11, 3'b001, 1'b0);
    push(r + 12, 3'b000, 1'b1);
    at_neg(r + 3);
    chk("c3_wait_before", o_wait_time, 2);
    i_input_coin = 3'b001;
    goto(r + 4);
    i_input_coin = 3'b000;
    @(negedge clk);
    chk("c3_wait_reload", o_wait_time, 5);
    at_neg(r + 9);
    chk("c3_wait_zero", o_wait_time, 0);
    chk("c3_busy_idle", o_busy, 0);
    at_neg(r + 13);
    chk("c3_queue_empty", q.size(), 0);

    // Case 4: trigger collides with a coin; pending request pays out 500 next.
    do_reset(r);
    i_trigger_return = 1'b1;
    i_input_coin = 3'b010;
    push(r + 3, 3'b010, 1'b0);
    push(r + 4, 3'b000, 1'b1);
    goto(r + 1);
    i_trigger_return = 1'b0;
    i_input_coin = 3'b000;
    i_balance_total = 31'd500;
    @(negedge clk);
    chk("c4_wait_reload", o_wait_time, 5);
    chk("c4_busy_pending", o_busy, 0);
    at_neg(r + 5);
    chk("c4_busy_after", o_busy, 0);
    chk("c4_queue_empty", q.size(), 0);

    // Case 5: zero balance request is dropped.
    do_reset(r);
    i_trigger_return = 1'b1;
    goto(r + 1);
    i_trigger_return = 1'b0;
    at_neg(r + 3);
    chk("c5_busy", o_busy, 0);
    chk("c5_wait", o_wait_time, 2);
    at_neg(r + 8);
    chk("c5_busy_late", o_busy, 0);
    chk("c5_wait_sat", o_wait_time, 0);
    chk("c5_queue_empty", q.size(), 0);

    // Case 6: reset right after the first coin of 2000.
    do_reset(r);
    i_balance_total = 31'd2000;
    i_trigger_return = 1'b1;
    push(r + 2, 3'b100, 1'b0);
    goto(r + 1);
    i_trigger_return = 1'b0;
    goto(r + 2);
    reset = 1'b1;
    goto(r + 3);
    reset = 1'b0;
    @(negedge clk);
    chk("c6_coin", o_return_coin, 0);
    chk("c6_busy", o_busy, 0);
    chk("c6_wait", o_wait_time, 5);
    at_neg(r + 6);
    chk("c6_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
